// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a 4-row weight tile, bursts it into a 4x4 weight-stationary array,
// streams skewed activations and captures results. Build option: FEEDER_SKEW_EN (per-lane diagonal skew).
module systolic_feeder #(
    parameter int ARRAY_LAT = 6,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_n_vec,
    input  logic [12:0]      i_param_in,
    input  logic             i_relu_in,
    input  logic             i_w_valid,
    output logic             o_w_ready,
    input  logic [127:0]     i_w_data,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [31:0]      i_a_data,
    output logic             o_we_valid,
    output logic [127:0]     o_weight,
    output logic             o_ac_valid,
    output logic [31:0]      o_activate,
    output logic [12:0]      o_matmul_param,
    output logic             o_relu,
    input  logic [31:0]      i_matmul_data,
    output logic             o_res_valid,
    output logic [31:0]      o_res_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_dbg_state
);

`ifdef FEEDER_SKEW_EN
    localparam int CAP_D = ARRAY_LAT + 3;
`else
    localparam int CAP_D = ARRAY_LAT;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_FILL   = 3'd1,
        S_W_BURST  = 3'd2,
        S_A_STREAM = 3'd3,
        S_FLUSH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_acnt;
    logic [CNT_W-1:0] r_rcnt;
    logic [12:0]      r_param;
    logic             r_relu;
    logic [127:0]     r_wbuf [4];
    logic [1:0]       r_wcnt;
    logic [1:0]       r_bcnt;
    logic             r_v0;
    logic [CAP_D-1:0] r_dl;
    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic             w_w_acc;
    logic             w_a_acc;
    logic             w_tap;
    logic             w_adv;
    logic [31:0]      w_in_data;

    // Handshake: a beat transfers on the rising edge where valid && ready are both high;
    // ready is a function of state only and never waits on valid.
    assign w_w_acc   = i_w_valid && o_w_ready;
    assign w_a_acc   = i_a_valid && o_a_ready;
    assign w_tap     = r_dl[CAP_D-1];
    assign w_adv     = (r_state == S_A_STREAM) || (r_state == S_FLUSH);
    assign w_in_data = w_a_acc ? i_a_data : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_w_ready  = 1'b0;
        o_a_ready  = 1'b0;
        o_we_valid = 1'b0;
        o_weight   = '0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_W_FILL;
            end
            S_W_FILL: begin
                o_w_ready = 1'b1;
                if (i_w_valid && (r_wcnt == 2'd3)) w_next = S_W_BURST;
            end
            S_W_BURST: begin
                o_we_valid = 1'b1;
                o_weight   = r_wbuf[r_bcnt];
                if (r_bcnt == 2'd3) w_next = (r_n == '0) ? S_DONE : S_A_STREAM;
            end
            S_A_STREAM: begin
                o_a_ready = (r_acnt < r_n);
                if (i_a_valid && (r_acnt == r_n - CNT_W'(1))) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                // Leave on the capture of the final result so DONE lines up with its res_valid.
                if (w_tap && (r_rcnt == r_n - CNT_W'(1))) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n     <= '0;
            r_param <= '0;
            r_relu  <= 1'b0;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_acnt  <= '0;
            r_rcnt  <= '0;
            for (int k = 0; k < 4; k++) r_wbuf[k] <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_n     <= i_n_vec;
            r_param <= i_param_in;
            r_relu  <= i_relu_in;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_acnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            if (w_w_acc) begin
                r_wbuf[r_wcnt] <= i_w_data;
                r_wcnt         <= r_wcnt + 2'd1;
            end
            if (o_we_valid) r_bcnt <= r_bcnt + 2'd1;
            if (w_a_acc) r_acnt <= r_acnt + CNT_W'(1);
            if (w_tap) r_rcnt <= r_rcnt + CNT_W'(1);
        end
    end

`ifdef FEEDER_SKEW_EN
    // Lane k carries a (k+1)-deep shift chain; only its oldest byte reaches the array.
    logic [7:0]  r_l0;
    logic [15:0] r_l1;
    logic [23:0] r_l2;
    logic [31:0] r_l3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_l0 <= '0;
            r_l1 <= '0;
            r_l2 <= '0;
            r_l3 <= '0;
        end else if (w_adv) begin
            r_l0 <= w_in_data[7:0];
            r_l1 <= {r_l1[7:0], w_in_data[15:8]};
            r_l2 <= {r_l2[15:0], w_in_data[23:16]};
            r_l3 <= {r_l3[23:0], w_in_data[31:24]};
        end
    end

    assign o_activate = {r_l3[31:24], r_l2[23:16], r_l1[15:8], r_l0};
`else
    logic [31:0] r_act;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act <= '0;
        end else if (w_adv) begin
            r_act <= w_in_data;
        end
    end

    assign o_activate = r_act;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v0        <= 1'b0;
            r_dl        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_adv) r_v0 <= w_a_acc;
            r_dl        <= {r_dl[CAP_D-2:0], w_a_acc};
            r_res_valid <= w_tap;
            r_res_data  <= w_tap ? i_matmul_data : '0;
        end
    end

    assign o_ac_valid     = r_v0;
    assign o_res_valid    = r_res_valid;
    assign o_res_data     = r_res_data;
    assign o_matmul_param = o_busy ? r_param : '0;
    assign o_relu         = o_busy && r_relu;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed bench for systolic_feeder with a behavioural array model
// that re-aligns the skewed lanes so each result equals the activation vector that produced it.
module tb_systolic_feeder;
    localparam int LAT   = 6;
    localparam int CNT_W = 16;
`ifdef FEEDER_SKEW_EN
    localparam int SKEW  = 1;
`else
    localparam int SKEW  = 0;
`endif
    localparam int CAP_D = SKEW ? LAT + 3 : LAT;
    localparam int J0 = CAP_D - 2;
    localparam int J1 = CAP_D - 2 - SKEW;
    localparam int J2 = CAP_D - 2 - 2 * SKEW;
    localparam int J3 = CAP_D - 2 - 3 * SKEW;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_vec;
    logic [12:0]      param_in;
    logic             relu_in;
    logic             w_valid;
    logic             w_ready;
    logic [127:0]     w_data;
    logic             a_valid;
    logic             a_ready;
    logic [31:0]      a_data;
    logic             we_valid;
    logic [127:0]     weight;
    logic             ac_valid;
    logic [31:0]      activate;
    logic [12:0]      matmul_param;
    logic             relu;
    logic [31:0]      matmul_data;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             busy;
    logic             done;
    logic [2:0]       dbg_state;

    systolic_feeder #(.ARRAY_LAT(LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_n_vec(n_vec),
        .i_param_in(param_in), .i_relu_in(relu_in),
        .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_data(a_data),
        .o_we_valid(we_valid), .o_weight(weight),
        .o_ac_valid(ac_valid), .o_activate(activate),
        .o_matmul_param(matmul_param), .o_relu(relu), .i_matmul_data(matmul_data),
        .o_res_valid(res_valid), .o_res_data(res_data),
        .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- array model ----------------
    logic [31:0] hist [8];
    always @(posedge clk) begin
        hist[0] <= activate;
        for (int j = 1; j < 8; j++) hist[j] <= hist[j-1];
    end
    assign matmul_data = {hist[J3][31:24], hist[J2][23:16], hist[J1][15:8], hist[J0][7:0]};

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];
    int          exp_t [$];
    int acc_cnt = 0;
    int res_cnt = 0;
    int ar_cnt  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            exp_q.push_back(a_data);
            exp_t.push_back(cyc + 1 + CAP_D);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && a_ready) ar_cnt++;
        if (rst_n && res_valid) begin
            res_cnt++;
            check("res_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                check("res_data", res_data, exp_q.pop_front());
                check("res_cycle", cyc, exp_t.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] wrow(input int r, input int salt);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(((r + 1) << 4) | k) ^ 8'(salt);
        return v;
    endfunction

    function automatic logic [31:0] avec(input int job, input int i);
        logic [31:0] v;
        v[7:0]   = 8'(8'h11 + job + i);
        v[15:8]  = 8'(8'h50 + i);
        v[23:16] = 8'(8'hA0 + job);
        v[31:24] = 8'(8'hC0 + i);
        return v;
    endfunction

    task automatic do_start(input int n, input logic [12:0] p, input logic r, output int t);
        n_vec    = CNT_W'(n);
        param_in = p;
        relu_in  = r;
        start    = 1'b1;
        t        = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_weights(input int gap, input int salt, output int c);
        for (int r = 0; r < 4; r++) begin
            int w;
            w       = 0;
            w_valid = 1'b1;
            w_data  = wrow(r, salt);
            while (!w_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("w_ready_wait", w_ready, 1'b1);
            c = cyc;
            @(negedge clk);
            w_valid = 1'b0;
            w_data  = '0;
            if (r < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_acts(input int n, input int stall, input int job, output int last);
        int w;
        int sent;
        int k;
        last = -1;
        if (n > 0) begin
            w = 0;
            while (!a_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("a_ready_wait", a_ready, 1'b1);
            sent = 0;
            k    = 0;
            while (sent < n && k < 4 * n + 8) begin
                if (stall != 0 && (k % 3) == 2) begin
                    a_valid = 1'b0;
                    a_data  = '0;
                end else begin
                    a_valid = 1'b1;
                    a_data  = avec(job, sent);
                    last    = cyc;
                    sent++;
                end
                @(negedge clk);
                k++;
            end
            a_valid = 1'b0;
            a_data  = '0;
        end
    endtask

    task automatic wait_done(output int dc);
        int w;
        w = 0;
        while (!done && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", done, 1'b1);
        dc = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_ready"}, w_ready, 0);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_we_valid"}, we_valid, 0);
        check({tag, "_weight"}, weight, 0);
        check({tag, "_ac_valid"}, ac_valid, 0);
        check({tag, "_activate"}, activate, 0);
        check({tag, "_matmul_param"}, matmul_param, 0);
        check({tag, "_relu"}, relu, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // ---------------- job table ----------------
    typedef struct {
        int         n;
        int         stall;
        logic [12:0] prm;
        logic       rl;
        int         poke;
        int         off;
        int         add_d;
    } job_t;

    job_t jobs [5];

    task automatic run_job(input int i);
        int t, c, last, dc;
        acc_cnt = 0;
        res_cnt = 0;
        ar_cnt  = 0;
        do_start(jobs[i].n, jobs[i].prm, jobs[i].rl, t);
        check("busy_t1", busy, 1'b1);
        check("param_t1", matmul_param, jobs[i].prm);
        check("relu_t1", relu, jobs[i].rl);
        send_weights(0, i + 1, c);
        check("wfill_end", c - t, 4);
        if (jobs[i].poke != 0) begin
            start    = 1'b1;
            n_vec    = CNT_W'(3);
            param_in = 13'h1fff;
            relu_in  = ~jobs[i].rl;
            @(negedge clk);
            start    = 1'b0;
            n_vec    = CNT_W'(jobs[i].n);
            param_in = jobs[i].prm;
            relu_in  = jobs[i].rl;
        end
        send_acts(jobs[i].n, jobs[i].stall, i, last);
        wait_done(dc);
        check("done_cycle", dc - t, jobs[i].off + jobs[i].add_d * CAP_D);
        check("param_done", matmul_param, jobs[i].prm);
        check("relu_done", relu, jobs[i].rl);
        @(negedge clk);
        check("done_len", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("param_idle", matmul_param, 0);
        check("relu_idle", relu, 1'b0);
        check("acc_count", acc_cnt, jobs[i].n);
        check("res_count", res_cnt, jobs[i].n);
        check("a_ready_cycles", ar_cnt, jobs[i].off - 9);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] exp_act [4];
        int t, c, a, dc, last;

        // {n, stall, param, relu, poke, done offset without capture delay, add capture delay}
        jobs[0] = '{1, 0, 13'h0305, 1'b1, 1, 10, 1};
        jobs[1] = '{4, 0, 13'h00ff, 1'b0, 0, 13, 1};
        jobs[2] = '{8, 1, 13'h1a5c, 1'b1, 0, 20, 1};
        jobs[3] = '{0, 0, 13'h0001, 1'b0, 0, 9, 0};
        jobs[4] = '{5, 1, 13'h1234, 1'b1, 0, 16, 1};

        if (SKEW != 0) begin
            exp_act[0] = 32'h0000_0011;
            exp_act[1] = 32'h0000_2200;
            exp_act[2] = 32'h0033_0000;
            exp_act[3] = 32'h4400_0000;
        end else begin
            exp_act[0] = 32'h4433_2211;
            exp_act[1] = 32'h0;
            exp_act[2] = 32'h0;
            exp_act[3] = 32'h0;
        end

        rst_n    = 1'b0;
        start    = 1'b0;
        n_vec    = '0;
        param_in = '0;
        relu_in  = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        a_valid  = 1'b0;
        a_data   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", dbg_state, 0);

        // Weight burst with 2-cycle gaps, then single-vector skew
        do_start(1, 13'h0042, 1'b0, t);
        send_weights(2, 0, c);
        check("wfill_gaps", c - t, 10);
        for (int i = 0; i < 4; i++) begin
            check("burst_we", we_valid, 1'b1);
            check("burst_row", weight, wrow(i, 0));
            check("burst_w_ready", w_ready, 1'b0);
            @(negedge clk);
        end
        check("burst_end_we", we_valid, 1'b0);
        check("burst_end_weight", weight, 0);
        check("skew_a_ready", a_ready, 1'b1);
        a_valid = 1'b1;
        a_data  = 32'h4433_2211;
        a       = cyc;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = '0;
        for (int i = 0; i < 4; i++) begin
            check("skew_activate", activate, exp_act[i]);
            check("skew_ac_valid", ac_valid, i == 0);
            @(negedge clk);
        end
        wait_done(dc);
        check("skew_done_cycle", dc, a + CAP_D + 1);
        @(negedge clk);

        // Reset in the middle of A_STREAM after 3 of 8 vectors
        do_start(8, 13'h0aaa, 1'b1, t);
        send_weights(0, 7, c);
        send_acts(3, 0, 7, last);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_ac_valid", ac_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        exp_q.delete();
        exp_t.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_job(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
